fc_core_ctrl: RTL and testbench

//  Sequencer for one fully connected layer on the single-MAC FC core.
//  On i_start it walks OUT_NODE output neurons. For each neuron it:
//   - clears the core accumulator,
//   - streams IN_NODE node/weight pairs from external 1-cycle-latency ROM/BRAMs,
//   - adds the bias and writes the result to a result memory.

---
 rtl/fc_pkg.sv | 30 +++
 rtl/fc_idx_cnt.sv | 41 ++++
 rtl/fc_core_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_fc_core_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// fc_pkg: shared definitions for the fully connected layer sequencer.
//   - FSM state encoding
//   - number of drain cycles between the last MAC issue and the result write
//   - result-width helper (accumulator is four times the operand width)
package fc_pkg;

  localparam logic [2:0] S_IDLE_ENC  = 3'd0;
  localparam logic [2:0] S_CLEAR_ENC = 3'd1;
  localparam logic [2:0] S_MAC_ENC   = 3'd2;
  localparam logic [2:0] S_DRAIN_ENC = 3'd3;
  localparam logic [2:0] S_WRITE_ENC = 3'd4;
  localparam logic [2:0] S_DONE_ENC  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = S_IDLE_ENC,
    S_CLEAR = S_CLEAR_ENC,
    S_MAC   = S_MAC_ENC,
    S_DRAIN = S_DRAIN_ENC,
    S_WRITE = S_WRITE_ENC,
    S_DONE  = S_DONE_ENC
  } fc_state_e;

  // One cycle of memory read latency plus one cycle of core accumulate latency.
  localparam int DRAIN_CYCLES = 2;

  function automatic int res_width(input int data_width);
    return 4 * data_width;
  endfunction

endpackage

// File: rtl/fc_idx_cnt.sv
// fc_idx_cnt: index counter 0..CNT_MAX with synchronous clear and enable.
//   clk, reset : clock, async active-high reset
//   clr        : synchronous clear to 0 (wins over en)
//   en         : advance; wraps to 0 after CNT_MAX
//   cnt        : current index (registered)
//   tc         : terminal count, cnt == CNT_MAX
module fc_idx_cnt #(
  parameter int CNT_W   = 4,
  parameter int CNT_MAX = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] ONE_V = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;

  assign cnt = cnt_r;
  assign tc  = (cnt_r == MAX_V);

  // Index register: clear has priority, wrap at the terminal value so the
  // index never leaves 0..CNT_MAX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (en) begin
      cnt_r <= tc ? {CNT_W{1'b0}} : (cnt_r + ONE_V);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/fc_core_ctrl.sv
// fc_core_ctrl: sequencer for one fully connected layer on a single-MAC core.
//   For each of OUT_NODE neurons: clear the core, stream IN_NODE node/weight
//   pairs from 1-cycle-latency memories, add the bias, write the result.
// Ports:
//   clk, reset                 clock, async active-high reset
//   i_start / o_idle /
//   o_running / o_done         top-level handshake
//   o_node_*, i_node_q         node memory read port
//   o_wegt_*, i_wegt_q         weight memory read port
//   o_bias_*, i_bias_q         bias memory read port
//   o_core_*, i_core_result    MAC core drive and accumulator readback
//   o_res_*                    result memory write port
module fc_core_ctrl
  import fc_pkg::*;
#(
  parameter int IN_DATA_WIDTH = 8,
  parameter int IN_NODE       = 16,
  parameter int OUT_NODE      = 4,
  parameter int NODE_AW       = 4,
  parameter int WEGT_AW       = 6,
  parameter int OUT_AW        = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_start,
  output logic                         o_idle,
  output logic                         o_running,
  output logic                         o_done,
  output logic                         o_node_ce,
  output logic [NODE_AW-1:0]           o_node_addr,
  input  logic [IN_DATA_WIDTH-1:0]     i_node_q,
  output logic                         o_wegt_ce,
  output logic [WEGT_AW-1:0]           o_wegt_addr,
  input  logic [IN_DATA_WIDTH-1:0]     i_wegt_q,
  output logic                         o_bias_ce,
  output logic [OUT_AW-1:0]            o_bias_addr,
  input  logic [IN_DATA_WIDTH-1:0]     i_bias_q,
  output logic                         o_core_run,
  output logic                         o_core_valid,
  output logic [IN_DATA_WIDTH-1:0]     o_core_node,
  output logic [IN_DATA_WIDTH-1:0]     o_core_wegt,
  input  logic [4*IN_DATA_WIDTH-1:0]   i_core_result,
  output logic                         o_res_we,
  output logic [OUT_AW-1:0]            o_res_addr,
  output logic [4*IN_DATA_WIDTH-1:0]   o_res_data
);

  localparam int W     = IN_DATA_WIDTH;
  localparam int RES_W = res_width(IN_DATA_WIDTH);
  localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES - 1);
  localparam logic [WEGT_AW-1:0] WEGT_ONE = WEGT_AW'(1);

  fc_state_e state_r;
  fc_state_e state_nx_s;

  logic [NODE_AW-1:0] in_idx_s;
  logic               in_tc_s;
  logic [OUT_AW-1:0]  out_idx_s;
  logic               out_tc_s;
  logic [WEGT_AW-1:0] wegt_addr_r;
  logic [1:0]         drain_cnt_r;

  logic               idle_r;
  logic               running_r;
  logic               done_r;
  logic               rd_ce_r;
  logic               bias_ce_r;
  logic               core_run_r;
  logic               core_valid_r;
  logic               bias_vld_r;
  logic [W-1:0]       bias_r;
  logic               res_we_r;
  logic [RES_W-1:0]   res_data_r;
  logic [RES_W-1:0]   sum_s;

  fc_idx_cnt #(.CNT_W(NODE_AW), .CNT_MAX(IN_NODE - 1)) u_in_idx (
    .clk   (clk),
    .reset (reset),
    .clr   (state_r == S_CLEAR),
    .en    (state_r == S_MAC),
    .cnt   (in_idx_s),
    .tc    (in_tc_s)
  );

  fc_idx_cnt #(.CNT_W(OUT_AW), .CNT_MAX(OUT_NODE - 1)) u_out_idx (
    .clk   (clk),
    .reset (reset),
    .clr   (state_r == S_IDLE),
    .en    (state_r == S_WRITE),
    .cnt   (out_idx_s),
    .tc    (out_tc_s)
  );

  // Truncating add of the accumulator and zero-extended bias.
  assign sum_s = i_core_result + {{(RES_W - W){1'b0}}, bias_r};

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; i_start is only looked at in IDLE.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE:  state_nx_s = i_start ? S_CLEAR : S_IDLE;
      S_CLEAR: state_nx_s = S_MAC;
      S_MAC:   state_nx_s = in_tc_s ? S_DRAIN : S_MAC;
      S_DRAIN: state_nx_s = (drain_cnt_r == DRAIN_LAST) ? S_WRITE : S_DRAIN;
      S_WRITE: state_nx_s = out_tc_s ? S_DONE : S_CLEAR;
      S_DONE:  state_nx_s = S_IDLE;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Drain cycle counter, only runs while in DRAIN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drain_cnt_r <= 2'd0;
    end else if (state_r == S_DRAIN) begin
      drain_cnt_r <= drain_cnt_r + 2'd1;
    end else begin
      drain_cnt_r <= 2'd0;
    end
  end

  // Running weight address: out_idx*IN_NODE + in_idx without a multiplier.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wegt_addr_r <= {WEGT_AW{1'b0}};
    end else if (state_r == S_IDLE) begin
      wegt_addr_r <= {WEGT_AW{1'b0}};
    end else if (state_r == S_MAC) begin
      wegt_addr_r <= wegt_addr_r + WEGT_ONE;
    end else begin
      wegt_addr_r <= wegt_addr_r;
    end
  end

  // Control outputs registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_r       <= 1'b1;
      running_r    <= 1'b0;
      done_r       <= 1'b0;
      rd_ce_r      <= 1'b0;
      bias_ce_r    <= 1'b0;
      core_run_r   <= 1'b0;
      core_valid_r <= 1'b0;
      bias_vld_r   <= 1'b0;
      res_we_r     <= 1'b0;
    end else begin
      idle_r       <= (state_nx_s == S_IDLE);
      running_r    <= (state_nx_s != S_IDLE) && (state_nx_s != S_DONE);
      done_r       <= (state_nx_s == S_DONE);
      rd_ce_r      <= (state_nx_s == S_MAC);
      bias_ce_r    <= (state_nx_s == S_CLEAR);
      core_run_r   <= (state_nx_s == S_CLEAR);
      core_valid_r <= rd_ce_r;
      bias_vld_r   <= bias_ce_r;
      res_we_r     <= (state_nx_s == S_WRITE);
    end
  end

  // Bias capture one cycle after its read, and result capture on WRITE entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bias_r     <= {W{1'b0}};
      res_data_r <= {RES_W{1'b0}};
    end else begin
      bias_r     <= bias_vld_r ? i_bias_q : bias_r;
      res_data_r <= (state_nx_s == S_WRITE) ? sum_s : res_data_r;
    end
  end

  assign o_idle       = idle_r;
  assign o_running    = running_r;
  assign o_done       = done_r;
  assign o_node_ce    = rd_ce_r;
  assign o_node_addr  = in_idx_s;
  assign o_wegt_ce    = rd_ce_r;
  assign o_wegt_addr  = wegt_addr_r;
  assign o_bias_ce    = bias_ce_r;
  assign o_bias_addr  = out_idx_s;
  assign o_core_run   = core_run_r;
  assign o_core_valid = core_valid_r;
  // Operands pass straight through but read as zero when not being accumulated.
  assign o_core_node  = core_valid_r ? i_node_q : {W{1'b0}};
  assign o_core_wegt  = core_valid_r ? i_wegt_q : {W{1'b0}};
  assign o_res_we     = res_we_r;
  assign o_res_addr   = out_idx_s;
  assign o_res_data   = res_data_r;

endmodule

// File: tb/tb_fc_core_ctrl.sv
// tb_fc_core_ctrl: table-driven bench for fc_core_ctrl with memory and MAC
// core models; a second instance covers the 1x1 layer.
module tb_fc_core_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic i_start, i_start6;

  // Default-parameter instance signals
  logic        o_idle, o_running, o_done, o_node_ce, o_wegt_ce, o_bias_ce;
  logic [3:0]  o_node_addr;
  logic [5:0]  o_wegt_addr;
  logic [1:0]  o_bias_addr, o_res_addr;
  logic [7:0]  node_q, wegt_q, bias_q, o_core_node, o_core_wegt;
  logic        o_core_run, o_core_valid, o_res_we;
  logic [31:0] core_acc, o_res_data;

  // 1x1 instance signals
  logic        idle6, running6, done6, node_ce6, wegt_ce6, bias_ce6;
  logic [3:0]  node_addr6;
  logic [5:0]  wegt_addr6;
  logic [1:0]  bias_addr6, res_addr6;
  logic [7:0]  node_q6, wegt_q6, bias_q6, core_node6, core_wegt6;
  logic        core_run6, core_valid6, res_we6;
  logic [31:0] core_acc6, res_data6;

  fc_core_ctrl dut (
    .clk(clk), .reset(reset), .i_start(i_start),
    .o_idle(o_idle), .o_running(o_running), .o_done(o_done),
    .o_node_ce(o_node_ce), .o_node_addr(o_node_addr), .i_node_q(node_q),
    .o_wegt_ce(o_wegt_ce), .o_wegt_addr(o_wegt_addr), .i_wegt_q(wegt_q),
    .o_bias_ce(o_bias_ce), .o_bias_addr(o_bias_addr), .i_bias_q(bias_q),
    .o_core_run(o_core_run), .o_core_valid(o_core_valid),
    .o_core_node(o_core_node), .o_core_wegt(o_core_wegt),
    .i_core_result(core_acc),
    .o_res_we(o_res_we), .o_res_addr(o_res_addr), .o_res_data(o_res_data)
  );

  fc_core_ctrl #(.IN_NODE(1), .OUT_NODE(1)) dut6 (
    .clk(clk), .reset(reset), .i_start(i_start6),
    .o_idle(idle6), .o_running(running6), .o_done(done6),
    .o_node_ce(node_ce6), .o_node_addr(node_addr6), .i_node_q(node_q6),
    .o_wegt_ce(wegt_ce6), .o_wegt_addr(wegt_addr6), .i_wegt_q(wegt_q6),
    .o_bias_ce(bias_ce6), .o_bias_addr(bias_addr6), .i_bias_q(bias_q6),
    .o_core_run(core_run6), .o_core_valid(core_valid6),
    .o_core_node(core_node6), .o_core_wegt(core_wegt6),
    .i_core_result(core_acc6),
    .o_res_we(res_we6), .o_res_addr(res_addr6), .o_res_data(res_data6)
  );

  // Memory models (1-cycle read latency)
  logic [7:0] node_mem [16];
  logic [7:0] wegt_mem [64];
  logic [7:0] bias_mem [4];

  always @(posedge clk) begin
    if (o_node_ce) node_q <= node_mem[o_node_addr];
    if (o_wegt_ce) wegt_q <= wegt_mem[o_wegt_addr];
    if (o_bias_ce) bias_q <= bias_mem[o_bias_addr];
    if (node_ce6)  node_q6 <= 8'd3;
    if (wegt_ce6)  wegt_q6 <= 8'd5;
    if (bias_ce6)  bias_q6 <= 8'd7;
  end

  // MAC core models
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      core_acc  <= 32'd0;
      core_acc6 <= 32'd0;
    end else begin
      if (o_core_run)        core_acc <= 32'd0;
      else if (o_core_valid) core_acc <= core_acc + 32'(o_core_node) * 32'(o_core_wegt);
      if (core_run6)         core_acc6 <= 32'd0;
      else if (core_valid6)  core_acc6 <= core_acc6 + 32'(core_node6) * 32'(core_wegt6);
    end
  end

  // Activity monitors
  logic [31:0] res_mem [4];
  logic [31:0] res6 = 32'd0;
  int wr_cnt = 0, done_cnt = 0, run_cnt = 0, overlap_cnt = 0, addr_err = 0, wexp = 0;
  int wr6 = 0, done6_cnt = 0;

  always @(posedge clk) begin
    if (o_res_we) begin
      res_mem[o_res_addr] <= o_res_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (o_done) done_cnt <= done_cnt + 1;
    if (o_core_run) run_cnt <= run_cnt + 1;
    if (o_core_run && o_core_valid) overlap_cnt <= overlap_cnt + 1;
    if (o_idle && i_start) begin
      wexp <= 0;
    end else if (o_wegt_ce) begin
      if (o_wegt_addr != 6'(wexp) || o_node_addr != 4'(wexp % 16) || !o_node_ce)
        addr_err <= addr_err + 1;
      wexp <= wexp + 1;
    end
    if (res_we6) begin
      res6 <= res_data6;
      wr6  <= wr6 + 1;
    end
    if (done6) done6_cnt <= done6_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic load_pat(input int pat);
    for (int i = 0; i < 16; i++) node_mem[i] = (pat == 0) ? 8'd1 : (pat == 1) ? 8'(i) : 8'd255;
    for (int o = 0; o < 4; o++) begin
      bias_mem[o] = (pat == 0) ? 8'd0 : (pat == 1) ? 8'(o) : 8'd255;
      for (int i = 0; i < 16; i++)
        wegt_mem[o*16+i] = (pat == 0) ? 8'd1 : (pat == 1) ? 8'(o + 1) : 8'd255;
    end
  endtask

  // Pulse start, count cycles until o_done (bounded).
  task automatic run_layer(output int lat);
    @(negedge clk);
    i_start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      i_start = 1'b0;
      lat++;
    end while (!o_done && lat < 300);
    check("done_seen", {31'd0, o_done}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    int               pat;
    logic [3:0][31:0] exp;
    int               lat;
  } vec_t;

  vec_t vecs[3];
  int lat, wr0, d0, r0;

  initial begin
    vecs[0].pat = 0; vecs[0].lat = 81;
    vecs[1].pat = 1; vecs[1].lat = 81;
    vecs[2].pat = 2; vecs[2].lat = 81;
    for (int o = 0; o < 4; o++) begin
      vecs[0].exp[o] = 32'd16;
      vecs[1].exp[o] = 32'd120 + 32'd121 * 32'(o);
      vecs[2].exp[o] = 32'd1040655;
    end

    reset = 1'b1; i_start = 1'b0; i_start6 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_idle", {31'd0, o_idle}, 32'd1);
    check("rst_flags", {24'd0, o_running, o_done, o_node_ce, o_bias_ce, o_core_run,
                        o_core_valid, o_res_we, o_wegt_ce}, 32'd0);
    check("rst_res_data", o_res_data, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_idle", {31'd0, o_idle}, 32'd1);

    // T1..T3 from the table
    for (int v = 0; v < 3; v++) begin
      load_pat(vecs[v].pat);
      wr0 = wr_cnt; d0 = done_cnt; r0 = run_cnt;
      run_layer(lat);
      check($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].lat));
      check($sformatf("v%0d_writes", v), 32'(wr_cnt - wr0), 32'd4);
      check($sformatf("v%0d_dones", v), 32'(done_cnt - d0), 32'd1);
      check($sformatf("v%0d_clear_pulses", v), 32'(run_cnt - r0), 32'd4);
      for (int o = 0; o < 4; o++)
        check($sformatf("v%0d_res%0d", v, o), res_mem[o], vecs[v].exp[o]);
      check($sformatf("v%0d_addr_err", v), 32'(addr_err), 32'd0);
      check($sformatf("v%0d_run_valid_overlap", v), 32'(overlap_cnt), 32'd0);
      check($sformatf("v%0d_idle_after", v), {31'd0, o_idle}, 32'd1);
    end

    // T4: start pulses mid-run and in DONE are ignored
    load_pat(0);
    wr0 = wr_cnt; d0 = done_cnt;
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    repeat (29) @(negedge clk);
    i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    lat = 0;
    while (!o_done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("t4_done_seen", {31'd0, o_done}, 32'd1);
    i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    check("t4_idle_after_done", {31'd0, o_idle}, 32'd1);
    repeat (20) @(negedge clk);
    check("t4_writes", 32'(wr_cnt - wr0), 32'd4);
    check("t4_dones", 32'(done_cnt - d0), 32'd1);
    check("t4_still_idle", {31'd0, o_idle}, 32'd1);

    // T5: reset during MAC of neuron 2, then restart
    load_pat(2);
    wr0 = wr_cnt; d0 = done_cnt;
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    repeat (44) @(negedge clk);
    check("t5_in_mac", {31'd0, o_node_ce}, 32'd1);
    reset = 1'b1;
    #1;
    check("t5_rst_idle", {31'd0, o_idle}, 32'd1);
    check("t5_rst_flags", {24'd0, o_running, o_done, o_node_ce, o_bias_ce, o_core_run,
                           o_core_valid, o_res_we, o_wegt_ce}, 32'd0);
    check("t5_rst_addrs", {18'd0, o_node_addr, o_wegt_addr, o_bias_addr, o_res_addr}, 32'd0);
    check("t5_rst_data", {16'd0, o_core_node, o_core_wegt} | o_res_data, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);
    check("t5_writes_before_rst", 32'(wr_cnt - wr0), 32'd2);
    load_pat(0);
    run_layer(lat);
    check("t5_restart_latency", 32'(lat), 32'd81);
    for (int o = 0; o < 4; o++)
      check($sformatf("t5_res%0d", o), res_mem[o], 32'd16);

    // T6: 1x1 layer on the second instance
    @(negedge clk); i_start6 = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      i_start6 = 1'b0;
      lat++;
    end while (!done6 && lat < 50);
    check("t6_latency", 32'(lat), 32'd6);
    repeat (3) @(negedge clk);
    check("t6_result", res6, 32'd22);
    check("t6_writes", 32'(wr6), 32'd1);
    check("t6_dones", 32'(done6_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
